prbs_frame_checker: RTL



---
 rtl/prbs_frame_checker.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/prbs_frame_checker.sv
// PRBS-31 receive checker: self-seeds on each frame's first beat, checks the rest, tracks lock and error statistics.
// Optional first-error capture is compiled in with `define PRBS_CHK_FIRST_ERR_EN.
module prbs_frame_checker #(
   parameter int P_LOCK_FRAMES   = 4,
   parameter int P_UNLOCK_FRAMES = 2,
   parameter int P_CNT_W         = 32
) (
   input  logic               rx_user_clk_i,
   input  logic               rx_user_rst_i,
   input  logic [31:0]        rx_data_i,
   input  logic [1:0]         rx_vldb_i,
   input  logic               rx_valid_i,
   input  logic               rx_last_i,
   input  logic               rx_user_i,
   input  logic               clr_cnt_i,
   output logic               lock_o,
   output logic               err_pulse_o,
   output logic [P_CNT_W-1:0] bit_err_cnt_o,
   output logic [P_CNT_W-1:0] frame_cnt_o,
   output logic [P_CNT_W-1:0] bad_frame_cnt_o,
   output logic [31:0]        first_err_exp_o,
   output logic [31:0]        first_err_rcv_o,
   output logic               first_err_vld_o
);

   localparam int RUN_MAX = (P_LOCK_FRAMES > P_UNLOCK_FRAMES) ? P_LOCK_FRAMES : P_UNLOCK_FRAMES;
   localparam int RUN_W   = $clog2(RUN_MAX + 1);

   typedef enum logic {ST_SEED, ST_BODY}   frame_state_t;
   typedef enum logic {ST_HUNT, ST_LOCKED} lock_state_t;

   frame_state_t       frame_state_reg;
   lock_state_t        lock_state_reg;
   // PRBS-31 state is 31 bits; the earliest bit of a word never feeds the next word.
   logic [31:1]        ref_reg;
   logic               frame_err_reg;
   logic [RUN_W-1:0]   good_run_reg;
   logic [RUN_W-1:0]   bad_run_reg;
   logic               lock_reg;
   logic               err_pulse_reg;
   logic [P_CNT_W-1:0] bit_err_cnt_reg;
   logic [P_CNT_W-1:0] frame_cnt_reg;
   logic [P_CNT_W-1:0] bad_frame_cnt_reg;

   logic [31:0]        exp_word;
   logic [3:0]         byte_en;
   logic [31:0]        bit_mask;
   logic [31:0]        diff_word;
   logic [5:0]         err_bits;
   logic               check_beat;
   logic               mism;
   logic               eof;
   logic               frame_bad;
   logic               lock_evt;
   logic [RUN_W-1:0]   good_run_inc;
   logic [RUN_W-1:0]   bad_run_inc;

   function automatic logic [P_CNT_W-1:0] sat_add(input logic [P_CNT_W-1:0] a, input logic [5:0] b);
      logic [P_CNT_W:0] sum;
      sum = {1'b0, a} + (P_CNT_W+1)'(b);
      return sum[P_CNT_W] ? {P_CNT_W{1'b1}} : sum[P_CNT_W-1:0];
   endfunction

   // Next word from s[n] = s[n-31] ^ s[n-28], with in-word feedback terms expanded.
   genvar gi;
   generate
      for (gi = 0; gi < 28; gi++) begin : g_next_lo
         assign exp_word[gi] = ref_reg[gi+1] ^ ref_reg[gi+4];
      end
      for (gi = 28; gi < 31; gi++) begin : g_next_hi
         assign exp_word[gi] = ref_reg[gi+1] ^ ref_reg[gi-27] ^ ref_reg[gi-24];
      end
      assign exp_word[31] = ref_reg[1] ^ ref_reg[7];

      for (gi = 0; gi < 4; gi++) begin : g_mask
         assign byte_en[gi] = !rx_last_i || (rx_vldb_i == 2'd0) || (2'(gi) < rx_vldb_i);
         assign bit_mask[gi*8 +: 8] = {8{byte_en[gi]}};
      end
   endgenerate

   assign diff_word    = (exp_word ^ rx_data_i) & bit_mask;
   assign err_bits     = 6'($countones(diff_word));
   assign good_run_inc = good_run_reg + RUN_W'(1);
   assign bad_run_inc  = bad_run_reg + RUN_W'(1);

   always_comb begin
      check_beat = rx_valid_i && (frame_state_reg == ST_BODY);
      mism       = check_beat && (diff_word != 32'd0);
      eof        = rx_valid_i && rx_last_i;
      frame_bad  = rx_user_i || (check_beat && (frame_err_reg || mism));
      // A clean single-beat frame was never checked, so it leaves the lock runs alone.
      lock_evt   = eof && (check_beat || rx_user_i);
   end

   always_ff @(posedge rx_user_clk_i) begin
      if (rx_user_rst_i) begin
         frame_state_reg <= ST_SEED;
         ref_reg         <= '0;
         frame_err_reg   <= 1'b0;
      end else if (rx_valid_i) begin
         case (frame_state_reg)
            ST_SEED: begin
               ref_reg       <= rx_data_i[31:1];
               frame_err_reg <= 1'b0;
               if (!rx_last_i) frame_state_reg <= ST_BODY;
            end
            default: begin
               ref_reg <= lock_reg ? exp_word[31:1] : rx_data_i[31:1];
               if (rx_last_i) begin
                  frame_state_reg <= ST_SEED;
                  frame_err_reg   <= 1'b0;
               end else begin
                  frame_err_reg   <= frame_err_reg || mism;
               end
            end
         endcase
      end
   end

   always_ff @(posedge rx_user_clk_i) begin
      if (rx_user_rst_i) begin
         lock_state_reg <= ST_HUNT;
         lock_reg       <= 1'b0;
         good_run_reg   <= '0;
         bad_run_reg    <= '0;
      end else if (lock_evt) begin
         case (lock_state_reg)
            ST_HUNT: begin
               if (frame_bad) begin
                  good_run_reg <= '0;
               end else begin
                  bad_run_reg <= '0;
                  if (good_run_inc == RUN_W'(P_LOCK_FRAMES)) begin
                     lock_state_reg <= ST_LOCKED;
                     lock_reg       <= 1'b1;
                     good_run_reg   <= '0;
                  end else begin
                     good_run_reg   <= good_run_inc;
                  end
               end
            end
            default: begin
               if (!frame_bad) begin
                  bad_run_reg <= '0;
               end else if (bad_run_inc == RUN_W'(P_UNLOCK_FRAMES)) begin
                  lock_state_reg <= ST_HUNT;
                  lock_reg       <= 1'b0;
                  good_run_reg   <= '0;
                  bad_run_reg    <= '0;
               end else begin
                  bad_run_reg    <= bad_run_inc;
               end
            end
         endcase
      end
   end

   always_ff @(posedge rx_user_clk_i) begin
      if (rx_user_rst_i) begin
         err_pulse_reg     <= 1'b0;
         bit_err_cnt_reg   <= '0;
         frame_cnt_reg     <= '0;
         bad_frame_cnt_reg <= '0;
      end else begin
         err_pulse_reg <= mism;
         if (clr_cnt_i) begin
            bit_err_cnt_reg   <= '0;
            frame_cnt_reg     <= '0;
            bad_frame_cnt_reg <= '0;
         end else begin
            if (mism) bit_err_cnt_reg <= sat_add(bit_err_cnt_reg, err_bits);
            if (eof) frame_cnt_reg <= sat_add(frame_cnt_reg, 6'd1);
            if (eof && frame_bad) bad_frame_cnt_reg <= sat_add(bad_frame_cnt_reg, 6'd1);
         end
      end
   end

`ifdef PRBS_CHK_FIRST_ERR_EN
   logic [31:0] first_err_exp_reg;
   logic [31:0] first_err_rcv_reg;
   logic        first_err_vld_reg;

   always_ff @(posedge rx_user_clk_i) begin
      if (rx_user_rst_i || clr_cnt_i) begin
         first_err_exp_reg <= '0;
         first_err_rcv_reg <= '0;
         first_err_vld_reg <= 1'b0;
      end else if (mism && !first_err_vld_reg) begin
         first_err_exp_reg <= exp_word;
         first_err_rcv_reg <= rx_data_i & bit_mask;
         first_err_vld_reg <= 1'b1;
      end
   end

   assign first_err_exp_o = first_err_exp_reg;
   assign first_err_rcv_o = first_err_rcv_reg;
   assign first_err_vld_o = first_err_vld_reg;
`else
   assign first_err_exp_o = '0;
   assign first_err_rcv_o = '0;
   assign first_err_vld_o = 1'b0;
`endif

   assign lock_o          = lock_reg;
   assign err_pulse_o     = err_pulse_reg;
   assign bit_err_cnt_o   = bit_err_cnt_reg;
   assign frame_cnt_o     = frame_cnt_reg;
   assign bad_frame_cnt_o = bad_frame_cnt_reg;

endmodule
